// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - read-side pointer, empty/almost-empty flags and fill level for the async FIFO
module rptr_empty #(
  parameter int ADDRSIZE   = 4,
  parameter int AEMPTYSIZE = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rempty,
  output logic                arempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rerr_underflow
);

  localparam logic [ADDRSIZE:0] AEMPTY_LVL = AEMPTYSIZE[ADDRSIZE:0];

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wq2bin;
  logic [ADDRSIZE:0] level_next;
  logic              pop;

  // Pops are only honoured when the FIFO is not (pessimistically) empty
  always_comb begin
    pop        = rinc & ~rempty;
    rbinnext   = rbin + {{ADDRSIZE{1'b0}}, pop};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    level_next = wq2bin - rbinnext;
  end

  // Gray-to-binary of the synchronised write pointer: each bit is the XOR of itself and all higher bits
  always_comb begin
    wq2bin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wq2bin[i] = ^(rq2_wptr >> i);
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

  // Register pointers and flags; flags use rbinnext so a pop and a write-pointer move in one cycle stay consistent
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin           <= '0;
      rptr           <= '0;
      rempty         <= 1'b1;
      arempty        <= 1'b1;
      rlevel         <= '0;
      rerr_underflow <= 1'b0;
    end else begin
      rbin           <= rbinnext;
      rptr           <= rgraynext;
      rempty         <= (rgraynext == rq2_wptr);
      arempty        <= (level_next <= AEMPTY_LVL);
      rlevel         <= level_next;
      rerr_underflow <= rinc & rempty;
    end
  end

endmodule

// File: tb/tb_rptr_empty.sv
// tb/tb_rptr_empty.sv - self-checking bench for rptr_empty with directed and randomized stimulus
module tb_rptr_empty;
  localparam int A  = 4;
  localparam int AE = 1;
  localparam int M  = 32;
  localparam int D  = 16;

  logic         rclk = 1'b0;
  logic         rrst_n;
  logic         rinc;
  logic [A:0]   rq2_wptr;
  logic         rempty;
  logic         arempty;
  logic [A-1:0] raddr;
  logic [A:0]   rptr;
  logic [A:0]   rlevel;
  logic         rerr_underflow;

  int checks = 0;
  int errors = 0;

  // reference model: counts of entries read/written, modulo 2*depth
  int m_rd;
  int m_w;
  int m_level;
  bit m_empty;
  bit m_aempty;
  bit m_uf;

  rptr_empty #(.ADDRSIZE(A), .AEMPTYSIZE(AE)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rempty(rempty), .arempty(arempty), .raddr(raddr), .rptr(rptr),
    .rlevel(rlevel), .rerr_underflow(rerr_underflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [A:0] gray(input int b);
    logic [A:0] v;
    v = b[A:0];
    return v ^ (v >> 1);
  endfunction

  task automatic step(input bit rst_n, input bit inc, input int w);
    rrst_n   = rst_n;
    rinc     = inc;
    m_w      = w % M;
    rq2_wptr = gray(m_w);
    @(posedge rclk);
    if (!rst_n) begin
      m_rd = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_uf = 0;
    end else begin
      m_uf = inc && m_empty;
      if (inc && !m_empty) m_rd = (m_rd + 1) % M;
      m_level  = (m_w - m_rd + M) % M;
      m_empty  = (m_level == 0);
      m_aempty = (m_level <= AE);
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 1, 3);
    checks++; if (rptr !== 5'b00000) begin errors++; $display("FAIL reset_rptr: got %b expected 00000", rptr); end
    checks++; if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d expected 0", raddr); end
    checks++; if (rempty !== 1'b1 || arempty !== 1'b1) begin errors++; $display("FAIL reset_flags: got empty=%b aempty=%b expected 1 1", rempty, arempty); end
    checks++; if (rlevel !== 5'd0 || rerr_underflow !== 1'b0) begin errors++; $display("FAIL reset_level_uf: got level=%0d uf=%b expected 0 0", rlevel, rerr_underflow); end
  endtask

  task automatic test_basic_pop();
    logic [A-1:0] exp_addr [3];
    logic [A:0]   exp_lvl  [3];
    logic         exp_ae   [3];
    logic         exp_e    [3];
    exp_addr = '{4'd1, 4'd2, 4'd3};
    exp_lvl  = '{5'd2, 5'd1, 5'd0};
    exp_ae   = '{1'b0, 1'b1, 1'b1};
    exp_e    = '{1'b0, 1'b0, 1'b1};
    step(1, 0, 3);
    checks++; if (rempty !== 1'b0 || arempty !== 1'b0 || rlevel !== 5'd3) begin errors++; $display("FAIL fill3: got empty=%b aempty=%b level=%0d expected 0 0 3", rempty, arempty, rlevel); end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 3);
      checks++;
      if (raddr !== exp_addr[i] || rlevel !== exp_lvl[i] || arempty !== exp_ae[i] || rempty !== exp_e[i]) begin
        errors++;
        $display("FAIL pop%0d: got addr=%0d level=%0d aempty=%b empty=%b expected %0d %0d %b %b",
                 i + 1, raddr, rlevel, arempty, rempty, exp_addr[i], exp_lvl[i], exp_ae[i], exp_e[i]);
      end
    end
    checks++; if (rptr !== 5'b00010) begin errors++; $display("FAIL drained_rptr: got %b expected 00010", rptr); end
  endtask

  task automatic test_underflow();
    step(1, 1, 3);
    checks++; if (rptr !== 5'b00010 || rerr_underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got rptr=%b uf=%b expected 00010 1", rptr, rerr_underflow); end
    step(1, 0, 3);
    checks++; if (rerr_underflow !== 1'b0 || rptr !== 5'b00010) begin errors++; $display("FAIL underflow_clear: got rptr=%b uf=%b expected 00010 0", rptr, rerr_underflow); end
  endtask

  task automatic test_full_wrap();
    step(0, 0, 0);
    step(1, 0, 16);
    checks++; if (rlevel !== 5'd16 || rempty !== 1'b0) begin errors++; $display("FAIL full_level: got level=%0d empty=%b expected 16 0", rlevel, rempty); end
    for (int i = 0; i < 16; i++) step(1, 1, 16);
    checks++; if (rptr !== 5'b11000 || raddr !== 4'd0 || rempty !== 1'b1) begin errors++; $display("FAIL full_drain: got rptr=%b addr=%0d empty=%b expected 11000 0 1", rptr, raddr, rempty); end
    step(1, 0, 30);
    for (int i = 0; i < 14; i++) step(1, 1, 30);
    checks++; if (rptr !== 5'b10001) begin errors++; $display("FAIL rbin30_rptr: got %b expected 10001", rptr); end
    step(1, 0, 2);
    checks++; if (rlevel !== 5'd4 || rempty !== 1'b0) begin errors++; $display("FAIL wrap_level: got level=%0d empty=%b expected 4 0", rlevel, rempty); end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 0);
    step(1, 0, 5);
    for (int i = 0; i < 4; i++) step(1, 1, 5);
    checks++; if (raddr !== 4'd4 || rlevel !== 5'd1) begin errors++; $display("FAIL simul_setup: got addr=%0d level=%0d expected 4 1", raddr, rlevel); end
    step(1, 1, 6);
    checks++; if (raddr !== 4'd5 || rlevel !== 5'd1 || rempty !== 1'b0 || arempty !== 1'b1) begin errors++; $display("FAIL simul: got addr=%0d level=%0d empty=%b aempty=%b expected 5 1 0 1", raddr, rlevel, rempty, arempty); end
  endtask

  task automatic test_midop_reset();
    step(1, 0, 8);
    checks++; if (raddr !== 4'd5 || rlevel !== 5'd3) begin errors++; $display("FAIL midrst_setup: got addr=%0d level=%0d expected 5 3", raddr, rlevel); end
    step(0, 1, 8);
    checks++; if (rptr !== 5'b0 || rempty !== 1'b1 || rlevel !== 5'd0 || arempty !== 1'b1) begin errors++; $display("FAIL midrst: got rptr=%b empty=%b level=%0d aempty=%b expected 00000 1 0 1", rptr, rempty, rlevel, arempty); end
    step(1, 0, 8);
    checks++; if (rlevel !== 5'd8 || rempty !== 1'b0) begin errors++; $display("FAIL midrst_after: got level=%0d empty=%b expected 8 0", rlevel, rempty); end
  endtask

  task automatic test_random();
    int occ, add, w;
    bit inc, rst;
    step(0, 0, 0);
    w = 0;
    for (int n = 0; n < 400; n++) begin
      occ = (w - m_rd + M) % M;
      add = $urandom_range(0, 2);
      if (occ + add > D) add = D - occ;
      w   = (w + add) % M;
      inc = ($urandom_range(0, 99) < 55);
      rst = ($urandom_range(0, 99) == 0);
      step(!rst, inc, w);
      if (rst) w = 0;
      checks++;
      if (rptr !== gray(m_rd) || raddr !== m_rd[A-1:0] || rlevel !== m_level[A:0] ||
          rempty !== m_empty || arempty !== m_aempty || rerr_underflow !== m_uf) begin
        errors++;
        $display("FAIL random[%0d]: got rptr=%b addr=%0d level=%0d e=%b ae=%b uf=%b expected %b %0d %0d %b %b %b",
                 n, rptr, raddr, rlevel, rempty, arempty, rerr_underflow,
                 gray(m_rd), m_rd % D, m_level, m_empty, m_aempty, m_uf);
      end
    end
  endtask

  initial begin
    m_rd = 0; m_w = 0; m_level = 0; m_empty = 1; m_aempty = 1; m_uf = 0;
    test_reset();
    test_basic_pop();
    test_underflow();
    test_full_wrap();
    test_simultaneous();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
- Read-side pointer and empty-flag logic for the debug async FIFO; the counterpart of the write-pointer/full block.
- Holds the binary read pointer used to address the dual-port RAM and produces the Gray-coded read pointer that is synchronised into the write domain.
- Compares its next Gray pointer against the write pointer already double-synchronised into rclk, generating registered empty, almost-empty, fill level and an underflow pulse.
- Two-flop synchroniser is external; this block sees rq2_wptr only.

Parameters:
- ADDRSIZE, 4, RAM address width; depth = 2^ADDRSIZE, pointers are ADDRSIZE+1 bits.
- AEMPTYSIZE, 1, almost-empty threshold in entries; legal range 0..2^ADDRSIZE-1.

Ports:
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst_n  input  1  reset, synchronous, active-low; sampled on rclk rising edge.
- rinc  input  1  read request; pops one entry when rempty=0.
- rq2_wptr  input  ADDRSIZE+1  write pointer, Gray code, already synchronised into rclk.
- rempty  output  1  FIFO empty (registered).
- arempty  output  1  almost empty: level <= AEMPTYSIZE (registered).
- raddr  output  ADDRSIZE  RAM read address = rbin[ADDRSIZE-1:0].
- rptr  output  ADDRSIZE+1  Gray read pointer, registered, to write-domain synchroniser.
- rlevel  output  ADDRSIZE+1  entries held, 0..2^ADDRSIZE (registered).
- rerr_underflow  output  1  one-cycle pulse: rinc seen while rempty=1.

Behaviour:
- Reset when rrst_n=0 at a rising rclk edge, overriding rinc and rq2_wptr:
  - rbin=0, rptr=0, raddr=0.
  - rempty=1, arempty=1, rlevel=0, rerr_underflow=0.
  - Applies identically mid-operation.
- Pointer update:
  - rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDRSIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - Every edge: rbin<=rbinnext, rptr<=rgraynext.
  - raddr is combinational from rbin; RAM data for the current raddr is valid while rempty=0.
- Empty:
  - rempty <= (rgraynext == rq2_wptr).
  - Asserts on the same edge the pointer advances onto the synced write pointer.
  - Deasserts one rclk after rq2_wptr moves.
  - Pessimistic by design, since rq2_wptr lags the real write pointer.
- Level:
  - wq2bin = Gray-to-binary of rq2_wptr, computed combinationally by MSB-first XOR prefix.
  - rlevel <= (wq2bin - rbinnext) mod 2^(ADDRSIZE+1).
  - Full FIFO gives 2^ADDRSIZE; the pointer MSB disambiguates full from empty.
- Almost empty: arempty <= (level_next <= AEMPTYSIZE), where level_next is the same value loaded into rlevel. With AEMPTYSIZE=0, arempty equals rempty.
- Underflow:
  - rinc=1 while rempty=1: the pointer does not move.
  - rerr_underflow <= 1 for exactly the next cycle, then 0 unless the condition repeats.
  - Not sticky.
- Wrap-around: rbin rolls from 2^(ADDRSIZE+1)-1 to 0 with no special case; level arithmetic is modular.
- Simultaneous pop and rq2_wptr change in one cycle: the flags use rbinnext and the current rq2_wptr together, so they are consistent with both events.
- No combinational path from rinc to any output except raddr via registered rbin (i.e. none).

Test Plan:
- Reset while driving rinc=1, rq2_wptr=5'b00011 -> after edge: rptr=0, raddr=0, rempty=1, arempty=1, rlevel=0, rerr_underflow=0.
- Post-reset, rq2_wptr=5'b00010 (bin 3), rinc=0 -> next edge rempty=0, arempty=0, rlevel=3. Then rinc=1 for 3 cycles:
  - raddr 1,2,3 and rlevel 2,1,0.
  - arempty=1 after 2nd pop.
  - rempty=1 after 3rd pop; rptr=5'b00010.
- Underflow: rempty=1, rinc=1 for one cycle -> rptr unchanged, rerr_underflow=1 for exactly one cycle, then 0.
- Full and wrap, rbin=0:
  - rq2_wptr=5'b11000 (bin 16) -> rlevel=16, rempty=0.
  - 16 pops -> rptr=5'b11000, raddr=0, rempty=1.
  - With rbin=30 (rptr=5'b10001) and rq2_wptr=5'b00011 (bin 2) -> rlevel=4, rempty=0.
- Simultaneous: rbin=4, rq2_wptr changes from gray(5)=00111 to gray(6)=00101 in the same cycle as rinc=1 -> rbin=5, rlevel=1, rempty=0, arempty=1.
- Mid-operation reset: rbin=5, rlevel=3, rrst_n=0 for one edge with rinc=1 -> rptr=0, rempty=1, rlevel=0. After rrst_n=1 with rq2_wptr=gray(8)=5'b01100 -> rlevel=8 next edge.
